ce_gen_frac: RTL and testbench

Multi-channel fractional clock-enable generator driven by a single master clock. Produces per-channel clock-enable pulses and ~50% square waves at runtime-programmable ratios and phase offsets. Used where core sub-clocks (CPU, video, audio) must be retuned without reprogramming the analogue PLL. Sits directly behind the PLL output clock, and feeds the core's clock-enable inputs.

---
 rtl/ce_gen_frac_pkg.sv | 22 ++
 rtl/ce_gen_frac_ch.sv | 42 ++++
 rtl/ce_gen_frac.sv | 173 +++++++++++++++++
 tb/tb_ce_gen_frac.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ce_gen_frac_pkg.sv
// ce_gen_frac_pkg: shared types for the fractional clock-enable generator.
// Holds the FSM state enum and the per-channel configuration record.
package ce_gen_frac_pkg;

    // Sequencing of the realign / settle / run cycle
    typedef enum logic [1:0] {
        ALIGN   = 2'd0,
        SETTLE  = 2'd1,
        LOCKED  = 2'd2,
        PENDING = 2'd3
    } state_t;

    // Widest accumulator the configuration record can describe
    localparam int unsigned CFG_W = 32;

    // Per-channel configuration: increment and start phase
    typedef struct packed {
        logic [CFG_W-1:0] inc;
        logic [CFG_W-1:0] phase;
    } ch_cfg_t;

endpackage

// File: rtl/ce_gen_frac_ch.sv
// ce_gen_frac_ch: one phase-accumulator channel.
// On align the accumulator is loaded with the start value and ce_out is
// cleared; while running it adds inc every cycle, registering the carry as
// ce_out and the pre-add MSB as sq_out.
module ce_gen_frac_ch #(
    parameter int unsigned ACC_W = 24
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             align,
    input  logic             run,
    input  logic [ACC_W-1:0] inc,
    input  logic [ACC_W-1:0] align_val,
    output logic             ce_out,
    output logic             sq_out
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    // Full-width add so the top bit is the wrap carry
    always_comb begin
        sum = {1'b0, acc} + {1'b0, inc};
    end

    // Accumulator, clock-enable pulse and square-wave output
    always_ff @(posedge refclk) begin
        if (rst) begin
            acc    <= '0;
            ce_out <= 1'b0;
            sq_out <= 1'b0;
        end else if (align) begin
            acc    <= align_val;
            ce_out <= 1'b0;
        end else if (run) begin
            acc    <= sum[ACC_W-1:0];
            ce_out <= sum[ACC_W];
            sq_out <= acc[ACC_W-1];
        end
    end

endmodule

// File: rtl/ce_gen_frac.sv
// ce_gen_frac: multi-channel fractional clock-enable generator.
// Holds the align/settle/lock FSM, the config handshake and the shadow and
// active channel registers; each channel's accumulator lives in ce_gen_frac_ch.
// Optional feature macro CEGEN_PHASE_EN: when defined, per-channel start
// phases are stored and loaded on align; otherwise every channel aligns to 0.
module ce_gen_frac
    import ce_gen_frac_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned LOCK_DLY = 16
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [3:0]          cfg_ch,
    input  logic [ACC_W-1:0]    cfg_inc,
    input  logic [ACC_W-1:0]    cfg_phase,
    input  logic                cfg_commit,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] ce_out,
    output logic [CHANNELS-1:0] sq_out,
    output logic                locked
);

    localparam int unsigned CNT_W = (LOCK_DLY > 1) ? $clog2(LOCK_DLY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_DLY - 1);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic                 align;
    logic                 run;
    logic                 wr_acc;
    logic                 wr_ok;
    logic                 ch_in_range;
    logic                 commit;
    logic [CHANNELS-1:0]  wr_hit;

    logic [ACC_W-1:0]     inc_s [CHANNELS];
    logic [ACC_W-1:0]     inc_a [CHANNELS];
`ifdef CEGEN_PHASE_EN
    logic [ACC_W-1:0]     phase_s [CHANNELS];
    logic [ACC_W-1:0]     phase_a [CHANNELS];
`else
    logic                 unused_phase;
    assign unused_phase = ^cfg_phase;
`endif

    // Handshake decode and per-channel write select
    always_comb begin
        ch_in_range = ({1'b0, cfg_ch} < 5'(CHANNELS));
        wr_acc      = cfg_valid && cfg_ready;
        wr_ok       = wr_acc && ch_in_range;
        commit      = cfg_commit && cfg_ready;
        wr_hit      = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            wr_hit[i] = wr_ok && (cfg_ch == 4'(i));
        end
    end

    // FSM state register
    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= ALIGN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ALIGN:   state_nxt = SETTLE;
            SETTLE:  if (cnt == CNT_LAST) state_nxt = LOCKED;
            LOCKED: begin
                if (commit)     state_nxt = ALIGN;
                else if (wr_ok) state_nxt = PENDING;
            end
            PENDING: if (commit) state_nxt = ALIGN;
            default: state_nxt = ALIGN;
        endcase
    end

    // FSM outputs
    always_comb begin
        cfg_ready = (state == LOCKED) || (state == PENDING);
        locked    = cfg_ready;
        align     = (state == ALIGN);
        run       = !align;
    end

    // Settle counter: cleared on align, counts through settle
    always_ff @(posedge refclk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ALIGN) begin
            cnt <= '0;
        end else if (state == SETTLE) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Error pulse for an accepted write to a nonexistent channel
    always_ff @(posedge refclk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= wr_acc && !ch_in_range;
        end
    end

    // Shadow registers take accepted writes
    always_ff @(posedge refclk) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (rst) begin
                inc_s[i] <= '0;
            end else if (wr_hit[i]) begin
                inc_s[i] <= cfg_inc;
            end
        end
    end

    // Active registers: commit copies shadow, bypassing a same-cycle write
    always_ff @(posedge refclk) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (rst) begin
                inc_a[i] <= '0;
            end else if (commit) begin
                inc_a[i] <= wr_hit[i] ? cfg_inc : inc_s[i];
            end
        end
    end

`ifdef CEGEN_PHASE_EN
    // Phase shadow/active registers, same write and commit rules as inc
    always_ff @(posedge refclk) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (rst) begin
                phase_s[i] <= '0;
                phase_a[i] <= '0;
            end else begin
                if (wr_hit[i]) phase_s[i] <= cfg_phase;
                if (commit)    phase_a[i] <= wr_hit[i] ? cfg_phase : phase_s[i];
            end
        end
    end
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [ACC_W-1:0] align_val;
`ifdef CEGEN_PHASE_EN
        assign align_val = phase_a[g];
`else
        assign align_val = '0;
`endif
        ce_gen_frac_ch #(
            .ACC_W(ACC_W)
        ) u_ch (
            .refclk    (refclk),
            .rst       (rst),
            .align     (align),
            .run       (run),
            .inc       (inc_a[g]),
            .align_val (align_val),
            .ce_out    (ce_out[g]),
            .sq_out    (sq_out[g])
        );
    end

endmodule

// File: tb/tb_ce_gen_frac.sv
// tb_ce_gen_frac: self-checking bench for ce_gen_frac (CHANNELS=4, ACC_W=8,
// LOCK_DLY=4). A cycle-level reference model tracks cycles since realign and
// per-channel accumulators as plain integers; directed scenarios pin it with
// hand-derived counts, then randomized traffic exercises everything.
module tb_ce_gen_frac;
    import ce_gen_frac_pkg::*;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int LD  = 4;
`ifdef CEGEN_PHASE_EN
    localparam bit PH_EN = 1'b1;
`else
    localparam bit PH_EN = 1'b0;
`endif

    logic           refclk = 1'b0;
    logic           rst;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [3:0]     cfg_ch;
    logic [W-1:0]   cfg_inc;
    logic [W-1:0]   cfg_phase;
    logic           cfg_commit;
    logic           cfg_err;
    logic [NCH-1:0] ce_out;
    logic [NCH-1:0] sq_out;
    logic           locked;

    int checks = 0;
    int errors = 0;

    always #5 refclk = ~refclk;

    ce_gen_frac #(
        .CHANNELS(NCH),
        .ACC_W(W),
        .LOCK_DLY(LD)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .cfg_phase  (cfg_phase),
        .cfg_commit (cfg_commit),
        .cfg_err    (cfg_err),
        .ce_out     (ce_out),
        .sq_out     (sq_out),
        .locked     (locked)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: m_t = cycles since the align cycle (0 = aligning)
    ch_cfg_t        m_sh  [NCH];
    ch_cfg_t        m_act [NCH];
    int             m_acc [NCH];
    logic [NCH-1:0] m_ce;
    logic [NCH-1:0] m_sq;
    logic           m_err;
    int             m_t;
    bit             chk_en = 1'b0;

    always @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_sh[i]  = '0;
                m_act[i] = '0;
                m_acc[i] = 0;
            end
            m_ce  = '0;
            m_sq  = '0;
            m_err = 1'b0;
            m_t   = 0;
        end else begin
            bit ready;
            int s;
            ready = (m_t > LD);
            for (int i = 0; i < NCH; i++) begin
                if (m_t == 0) begin
                    m_acc[i] = PH_EN ? int'(m_act[i].phase) : 0;
                    m_ce[i]  = 1'b0;
                end else begin
                    s        = m_acc[i] + int'(m_act[i].inc);
                    m_sq[i]  = (m_acc[i] >= 2 ** (W - 1));
                    m_ce[i]  = (s >= 2 ** W);
                    m_acc[i] = s % (2 ** W);
                end
            end
            m_err = ready && cfg_valid && (cfg_ch >= NCH);
            if (ready && cfg_valid && (cfg_ch < NCH)) begin
                m_sh[cfg_ch].inc = 32'(cfg_inc);
                if (PH_EN) m_sh[cfg_ch].phase = 32'(cfg_phase);
            end
            if (ready && cfg_commit) begin
                for (int i = 0; i < NCH; i++) m_act[i] = m_sh[i];
                m_t = 0;
            end else if (m_t <= LD) begin
                m_t++;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge refclk) begin
        if (chk_en) begin
            chk("ce_out",    ce_out,    m_ce);
            chk("sq_out",    sq_out,    m_sq);
            chk("locked",    locked,    (m_t > LD));
            chk("cfg_ready", cfg_ready, (m_t > LD));
            chk("cfg_err",   cfg_err,   m_err);
        end
    end

    task automatic wr(input int ch, input int inc, input int ph, input bit commit);
        @(negedge refclk);
        cfg_valid  = 1'b1;
        cfg_ch     = 4'(ch);
        cfg_inc    = W'(inc);
        cfg_phase  = W'(ph);
        cfg_commit = commit;
        @(negedge refclk);
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic commit_only();
        @(negedge refclk);
        cfg_commit = 1'b1;
        @(negedge refclk);
        cfg_commit = 1'b0;
    endtask

    // Counts unlocked samples until lock, bounded
    task automatic wait_lock(input string name);
        int n;
        n = 0;
        while (!locked && n < 60) begin
            n++;
            @(negedge refclk);
        end
        chk(name, n, LD + 1);
    endtask

    // Phase relation between ch1 and ch0 pulses over one period of 4
    task automatic lead(input string name);
        int p0;
        int p1;
        p0 = -1;
        p1 = -1;
        for (int k = 0; k < 4; k++) begin
            if (ce_out[0]) p0 = k;
            if (ce_out[1]) p1 = k;
            @(negedge refclk);
        end
        chk(name, (p0 - p1 + 4) % 4, PH_EN ? 2 : 0);
    endtask

    initial begin
        int nce;
        int nsq;
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
        cfg_ch     = '0;
        cfg_inc    = '0;
        cfg_phase  = '0;
        repeat (3) @(negedge refclk);
        chk_en = 1'b1;
        chk("rst_ce", ce_out, 0);
        chk("rst_sq", sq_out, 0);
        chk("rst_locked", locked, 0);
        rst = 1'b0;
        wait_lock("release_lock_dly");

        // ch0 inc=64: period 4, square wave 2 high / 2 low
        wr(0, 64, 0, 1'b0);
        chk("pending_locked", locked, 1);
        commit_only();
        wait_lock("commit_lock_dly");
        nce = 0;
        nsq = 0;
        for (int k = 0; k < 16; k++) begin
            nce += int'(ce_out[0]);
            nsq += int'(sq_out[0]);
            @(negedge refclk);
        end
        chk("ch0_ce_per16", nce, 4);
        chk("ch0_sq_per16", nsq, 8);

        // ch1 half-period phase offset against ch0, survives a resync
        wr(1, 64, 128, 1'b0);
        wr(0, 64, 0, 1'b1);
        wait_lock("phase_lock_dly");
        lead("ch1_lead");
        commit_only();
        wait_lock("resync_lock_dly");
        lead("ch1_lead_resync");

        // write and commit in the same cycle, inc=255
        wr(2, 255, 0, 1'b1);
        wait_lock("same_cycle_lock_dly");
        nce = 0;
        for (int k = 0; k < 256; k++) begin
            nce += int'(ce_out[2]);
            @(negedge refclk);
        end
        chk("ch2_ce_per256", nce, 255);

        // out-of-range channel
        wr(9, 77, 33, 1'b0);
        chk("bad_ch_err", cfg_err, 1);
        chk("bad_ch_locked", locked, 1);
        @(negedge refclk);
        chk("bad_ch_err_clear", cfg_err, 0);

        // reset during settle clears everything including shadow
        commit_only();
        repeat (2) @(negedge refclk);
        rst = 1'b1;
        @(negedge refclk);
        chk("midrst_ce", ce_out, 0);
        chk("midrst_sq", sq_out, 0);
        chk("midrst_locked", locked, 0);
        rst = 1'b0;
        wait_lock("midrst_lock_dly");
        commit_only();
        wait_lock("postrst_lock_dly");
        nce = 0;
        for (int k = 0; k < 20; k++) begin
            nce += int'(|ce_out);
            @(negedge refclk);
        end
        chk("postrst_no_ce", nce, 0);

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            @(negedge refclk);
            rst        = ($urandom_range(0, 149) == 0);
            cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg_ch     = 4'($urandom_range(0, 9));
            cfg_inc    = W'($urandom);
            cfg_phase  = W'($urandom);
            cfg_commit = ($urandom_range(0, 11) == 0);
        end
        @(negedge refclk);
        rst        = 1'b0;
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
        repeat (10) @(negedge refclk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
